loop_monitor: RTL and testbench

LOOP_MONITOR -- requirements
Module: loop_monitor

---
 rtl/loop_monitor_if.sv | 30 +++
 rtl/loop_monitor.sv | 154 +++++++++++++++
 tb/tb_loop_monitor.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loop_monitor_if.sv
// loop_monitor bus: upstream loop-counter signals in,
// monitor status out.
interface loop_monitor_if #(
  parameter int W     = 15,
  parameter int CNT_W = 16
);
  logic             ctr_rst;
  logic             selector;
  logic [W-1:0]     i;
  logic [W-1:0]     y;
  logic [W-1:0]     x;
  logic [1:0]       state;
  logic             done;
  logic             error;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] step_count;
  logic             stall;

  modport master (
    output ctr_rst, selector, i, y, x,
    input  state, done, error, err_code,
    input  step_count, stall
  );

  modport slave (
    input  ctr_rst, selector, i, y, x,
    output state, done, error, err_code,
    output step_count, stall
  );
endinterface

// File: rtl/loop_monitor.sv
// loop_monitor: watches an upstream loop counter for
// bad steps, changed bounds, broken invariant and stalls.
module loop_monitor #(
  parameter int W           = 15,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1000
) (
  input logic           clk,
  input logic           rst,
  loop_monitor_if.slave mon
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(STALL_LIMIT);

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_i_q;
  logic [W-1:0]     r_y_q;
  logic [W-1:0]     r_x_q;
  logic             r_sel_q;
  logic [CNT_W-1:0] r_step;
  logic [CNT_W-1:0] w_step_nxt;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] w_scnt_nxt;
  logic             r_stall;
  logic             w_stall_nxt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic             r_done;
  logic             r_error;
  logic [W-1:0]     w_exp;
  logic             w_adv;
  logic             w_bad;
  logic             w_chg;
  logic             w_inv;
  logic             w_hold;

  // reset asserts at once, releases two edges later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_adv  = r_sel_q && (r_i_q < r_y_q);
  assign w_exp  = w_adv ? r_i_q + W'(1) : r_i_q;
  assign w_inv  = (mon.i < mon.y) &&
                  (mon.i >= mon.x);
  assign w_bad  = mon.i != w_exp;
  assign w_chg  = (mon.y != r_y_q) ||
                  (mon.x != r_x_q);
  assign w_hold = (mon.i == r_i_q) &&
                  (mon.i < mon.y);

  // next state, counters and error code
  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_scnt_nxt  = r_scnt;
    w_stall_nxt = r_stall;
    w_err_nxt   = r_err;
    if (mon.ctr_rst) begin
      w_state_nxt = S_IDLE;
      w_step_nxt  = '0;
      w_scnt_nxt  = '0;
      w_stall_nxt = 1'b0;
      w_err_nxt   = 2'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_step_nxt  = '0;
          w_scnt_nxt  = '0;
          w_stall_nxt = 1'b0;
          w_err_nxt   = 2'd0;
          w_state_nxt = (mon.i >= mon.y) ?
                        S_DONE : S_RUN;
        end
        S_RUN: begin
          if (w_inv) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 2'd3;
          end else if (w_bad) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 2'd1;
          end else if (w_chg) begin
            w_state_nxt = S_ERR;
            w_err_nxt   = 2'd2;
          end else begin
            if (w_adv) begin
              w_step_nxt = (&r_step) ? r_step :
                           r_step + CNT_W'(1);
              w_scnt_nxt = '0;
            end else if (w_hold) begin
              w_scnt_nxt = (&r_scnt) ? r_scnt :
                           r_scnt + CNT_W'(1);
              if (w_scnt_nxt >= LIM)
                w_stall_nxt = 1'b1;
            end
            if (mon.i == mon.y)
              w_state_nxt = S_DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // sample bus every cycle and register all outputs
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_i_q   <= '0;
      r_y_q   <= '0;
      r_x_q   <= '0;
      r_sel_q <= 1'b0;
      r_state <= S_IDLE;
      r_step  <= '0;
      r_scnt  <= '0;
      r_stall <= 1'b0;
      r_err   <= 2'd0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_i_q   <= mon.i;
      r_y_q   <= mon.y;
      r_x_q   <= mon.x;
      r_sel_q <= mon.selector;
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_scnt  <= w_scnt_nxt;
      r_stall <= w_stall_nxt;
      r_err   <= w_err_nxt;
      r_done  <= (w_state_nxt == S_DONE);
      r_error <= (w_state_nxt == S_ERR);
    end
  end

  assign mon.state      = r_state;
  assign mon.done       = r_done;
  assign mon.error      = r_error;
  assign mon.err_code   = r_err;
  assign mon.step_count = r_step;
  assign mon.stall      = r_stall;
endmodule

// File: tb/tb_loop_monitor.sv
// tb_loop_monitor: table vectors, directed loop scenarios
// and random traffic against a reference model.
module tb_loop_monitor;
  localparam int W     = 15;
  localparam int CNT_W = 16;
  localparam int LIM   = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  loop_monitor_if #(.W(W), .CNT_W(CNT_W)) mon();

  loop_monitor #(
    .W(W), .CNT_W(CNT_W), .STALL_LIMIT(LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(mon)
  );

  int checks = 0;
  int errors = 0;

  int m_state, m_step, m_scnt, m_err, m_stall;
  int p_i, p_y, p_x, p_sel;
  int m_rcnt = 0;
  int cnt = 0;

  typedef struct {
    bit c; bit s;
    int i; int y; int x;
    int st; int ec; int sc;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic m_zero();
    m_state = 0; m_step = 0; m_scnt = 0;
    m_err = 0; m_stall = 0;
    p_i = 0; p_y = 0; p_x = 0; p_sel = 0;
  endtask

  task automatic model_edge(bit c, bit s,
                            int ii, int yy, int xx);
    int e;
    if (!rst) begin
      m_rcnt = 0;
      m_zero();
      return;
    end
    if (m_rcnt < 2) begin
      m_rcnt++;
      m_zero();
      return;
    end
    if (c) begin
      m_state = 0; m_step = 0; m_scnt = 0;
      m_err = 0; m_stall = 0;
    end else if (m_state == 0) begin
      m_step = 0; m_scnt = 0;
      m_err = 0; m_stall = 0;
      m_state = (ii >= yy) ? 2 : 1;
    end else if (m_state == 1) begin
      e = (p_sel != 0 && p_i < p_y) ? p_i + 1 : p_i;
      if (ii < yy && ii >= xx) begin
        m_state = 3; m_err = 3;
      end else if (ii != e) begin
        m_state = 3; m_err = 1;
      end else if (yy != p_y || xx != p_x) begin
        m_state = 3; m_err = 2;
      end else begin
        if (ii == p_i + 1) begin
          if (m_step < 65535) m_step++;
          m_scnt = 0;
        end else if (ii == p_i && ii < yy) begin
          if (m_scnt < 65535) m_scnt++;
          if (m_scnt >= LIM) m_stall = 1;
        end
        if (ii == yy) m_state = 2;
      end
    end
    p_i = ii; p_y = yy; p_x = xx; p_sel = s;
  endtask

  task automatic cmp_model();
    chk("state", mon.state, m_state);
    chk("done", mon.done, m_state == 2);
    chk("error", mon.error, m_state == 3);
    chk("err_code", mon.err_code, m_err);
    chk("step_count", mon.step_count, m_step);
    chk("stall", mon.stall, m_stall);
  endtask

  task automatic cyc(bit c, bit s,
                     int ii, int yy, int xx);
    mon.ctr_rst  = c;
    mon.selector = s;
    mon.i = W'(ii);
    mon.y = W'(yy);
    mon.x = W'(xx);
    @(posedge clk);
    model_edge(c, s, ii, yy, xx);
    if (c) cnt = 0;
    else if (s && cnt < yy) cnt++;
    #1;
    cmp_model();
  endtask

  task automatic upreset();
    cyc(1'b1, 1'b1, cnt, 450, 500);
    cyc(1'b1, 1'b1, cnt, 450, 500);
  endtask

  task automatic runn(int n, bit s);
    for (int k = 0; k < n; k++)
      cyc(1'b0, s, cnt, 450, 500);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int ry, rx, r, ii, yy, xx;
    bit c, s;
    tbl[0]  = '{1,1,0,10,20, 0,0,0};
    tbl[1]  = '{0,1,0,10,20, 1,0,0};
    tbl[2]  = '{0,1,1,10,20, 1,0,1};
    tbl[3]  = '{0,1,2,10,20, 1,0,2};
    tbl[4]  = '{0,0,3,10,20, 1,0,3};
    tbl[5]  = '{0,0,3,10,20, 1,0,3};
    tbl[6]  = '{0,1,3,10,20, 1,0,3};
    tbl[7]  = '{0,1,5,10,20, 3,1,3};
    tbl[8]  = '{0,1,6,10,20, 3,1,3};
    tbl[9]  = '{1,1,0,10,20, 0,0,0};
    tbl[10] = '{0,1,9,10,20, 1,0,0};
    tbl[11] = '{0,1,10,10,20, 2,0,1};
    tbl[12] = '{0,1,10,10,20, 2,0,1};
    tbl[13] = '{1,1,0,10,20, 0,0,0};
    tbl[14] = '{0,1,12,10,20, 2,0,0};
    tbl[15] = '{1,0,0,10,20, 0,0,0};
    tbl[16] = '{0,0,5,10,20, 1,0,0};
    tbl[17] = '{0,0,5,11,20, 3,2,0};
    tbl[18] = '{1,1,0,10,20, 0,0,0};
    tbl[19] = '{0,1,5,10,20, 1,0,0};
    tbl[20] = '{0,1,7,10,5, 3,3,0};
    tbl[21] = '{1,0,0,10,20, 0,0,0};
    tbl[22] = '{0,0,10,10,20, 2,0,0};
    m_zero();

    // inputs toggle under reset, outputs stay zero
    for (int k = 0; k < 4; k++)
      cyc(1'($urandom_range(0, 1)), 1'b1,
          $urandom_range(0, 3000), 450, 500);
    rst = 1'b1;
    upreset();

    // table vectors
    foreach (tbl[k]) begin
      cyc(tbl[k].c, tbl[k].s, tbl[k].i,
          tbl[k].y, tbl[k].x);
      chk($sformatf("tbl%0d.state", k),
          mon.state, tbl[k].st);
      chk($sformatf("tbl%0d.err", k),
          mon.err_code, tbl[k].ec);
      chk($sformatf("tbl%0d.step", k),
          mon.step_count, tbl[k].sc);
    end

    // full loop to completion
    upreset();
    runn(1, 1'b1);
    chk("run.state", mon.state, 1);
    runn(449, 1'b1);
    chk("run.notdone", mon.done, 0);
    runn(1, 1'b1);
    chk("run.done", mon.done, 1);
    chk("run.step", mon.step_count, 450);
    chk("run.error", mon.error, 0);

    // ctr_rst pulse out of DONE
    cyc(1'b1, 1'b1, cnt, 450, 500);
    chk("rb.idle", mon.state, 0);
    chk("rb.done", mon.done, 0);
    cyc(1'b0, 1'b1, cnt, 450, 500);
    chk("rb.run", mon.state, 1);
    chk("rb.step", mon.step_count, 0);

    // stall after LIM no-progress cycles
    upreset();
    runn(1, 1'b0);
    runn(LIM - 1, 1'b0);
    chk("stall.pre", mon.stall, 0);
    runn(1, 1'b0);
    chk("stall.set", mon.stall, 1);
    chk("stall.state", mon.state, 1);
    runn(451, 1'b1);
    chk("stall.done", mon.done, 1);
    chk("stall.step", mon.step_count, 450);
    chk("stall.hold", mon.stall, 1);

    // bad step 10 -> 12
    upreset();
    runn(11, 1'b1);
    cyc(1'b0, 1'b1, 12, 450, 500);
    chk("bad.state", mon.state, 3);
    chk("bad.err", mon.err_code, 1);
    chk("bad.step", mon.step_count, 10);
    runn(3, 1'b1);
    chk("bad.frozen", mon.step_count, 10);

    // bound changed
    upreset();
    runn(101, 1'b1);
    cyc(1'b0, 1'b1, cnt, 451, 500);
    chk("chg.err", mon.err_code, 2);

    // invariant broken
    upreset();
    runn(100, 1'b1);
    cyc(1'b0, 1'b1, 100, 450, 100);
    chk("inv.err", mon.err_code, 3);

    // invariant wins over bad step
    upreset();
    runn(101, 1'b1);
    cyc(1'b0, 1'b1, 103, 450, 100);
    chk("prio.err", mon.err_code, 3);

    // async reset mid-run at i=200
    upreset();
    runn(201, 1'b1);
    #2 rst = 1'b0;
    #1;
    m_rcnt = 0;
    m_zero();
    chk("arst.state", mon.state, 0);
    chk("arst.step", mon.step_count, 0);
    chk("arst.done", mon.done, 0);
    chk("arst.error", mon.error, 0);
    chk("arst.err", mon.err_code, 0);
    chk("arst.stall", mon.stall, 0);
    runn(2, 1'b1);
    rst = 1'b1;
    runn(3, 1'b1);
    chk("arst.rebase", mon.state, 1);
    chk("arst.step0", mon.step_count, 0);
    runn(5, 1'b1);
    chk("arst.step5", mon.step_count, 5);

    // random traffic against the model
    ry = 200; rx = 300;
    cyc(1'b1, 1'b1, cnt, ry, rx);
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 99);
      c = (r < 2);
      s = ($urandom_range(0, 3) != 0);
      if (c) begin
        ry = $urandom_range(1, 300);
        rx = $urandom_range(ry, ry + 200);
      end
      ii = cnt; yy = ry; xx = rx;
      if (r >= 2 && r <= 3)
        ii = cnt + $urandom_range(1, 3);
      else if (r == 4 && cnt > 0)
        ii = cnt - 1;
      else if (r == 5)
        yy = ry + 1;
      else if (r == 6)
        xx = $urandom_range(0, ry);
      cyc(c, s, ii, yy, xx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
